seq_pattern_tx: RTL and testbench

Serial pattern transmitter, the generator counterpart of the 10110 Mealy sequence detectors. On a start request it drives a fixed bit pattern, MSB first and one bit per clock, onto the serial line `j`. The pattern is sent a programmable number of times, with an optional idle gap between copies. Its `j` output connects directly to the detectors' `j` input, for self-checking benches and on-chip loopback.

---
 rtl/seq_pattern_tx.sv | 129 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first on j, repeat_n copies
// separated by gap_n idle cycles, with busy/last_bit/done status.
module seq_pattern_tx #(
    parameter int              PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
    parameter int              CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [CNT_W-1:0] gap_n,
    output logic             j,
    output logic             busy,
    output logic             last_bit,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [CNT_W-1:0]   rep_cnt_reg, rep_cnt_next;
    logic [CNT_W-1:0]   gap_reg, gap_next;
    logic [CNT_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic               j_reg, j_next;
    logic               busy_reg, busy_next;
    logic               last_reg, last_next;
    logic               done_reg, done_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            rep_cnt_reg <= '0;
            gap_reg     <= '0;
            gap_cnt_reg <= '0;
            j_reg       <= 1'b0;
            busy_reg    <= 1'b0;
            last_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            rep_cnt_reg <= rep_cnt_next;
            gap_reg     <= gap_next;
            gap_cnt_reg <= gap_cnt_next;
            j_reg       <= j_next;
            busy_reg    <= busy_next;
            last_reg    <= last_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        rep_cnt_next = rep_cnt_reg;
        gap_next     = gap_reg;
        gap_cnt_next = gap_cnt_reg;
        j_next       = 1'b0;
        busy_next    = busy_reg;
        last_next    = 1'b0;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (start && (repeat_n != '0)) begin
                    rep_cnt_next = repeat_n;
                    gap_next     = gap_n;
                    j_next       = PATTERN[PAT_W-1];
                    busy_next    = 1'b1;
                    idx_next     = IDX_W'(PAT_W - 2);
                    state_next   = SEND;
                end
            end
            SEND: begin
                // last_reg marks that PATTERN[0] is on the line: this edge ends the copy
                if (!last_reg) begin
                    j_next    = PATTERN[idx_reg];
                    last_next = (idx_reg == '0);
                    if (idx_reg != '0)
                        idx_next = idx_reg - 1'b1;
                end else if (rep_cnt_reg == CNT_W'(1)) begin
                    rep_cnt_next = '0;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end else begin
                    rep_cnt_next = rep_cnt_reg - 1'b1;
                    if (gap_reg == '0) begin
                        j_next   = PATTERN[PAT_W-1];
                        idx_next = IDX_W'(PAT_W - 2);
                    end else begin
                        gap_cnt_next = gap_reg;
                        state_next   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == CNT_W'(1)) begin
                    gap_cnt_next = '0;
                    j_next       = PATTERN[PAT_W-1];
                    idx_next     = IDX_W'(PAT_W - 2);
                    state_next   = SEND;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign j        = j_reg;
    assign busy     = busy_reg;
    assign last_bit = last_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx against a cycle-stream model that expands
// each accepted request into its expected per-cycle (j, busy, last_bit, done) trace.
module tb_seq_pattern_tx;

    localparam int         PAT_W = 5;
    localparam logic [4:0] PAT   = 5'b10110;
    localparam int         CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] repeat_n;
    logic [CNT_W-1:0] gap_n;
    logic             j, busy, last_bit, done;

    int checks   = 0;
    int failures = 0;

    // expected value per cycle: [3]=j [2]=busy [1]=last_bit [0]=done
    logic [3:0] exp_q[$];
    logic [3:0] cur = 4'b0;

    seq_pattern_tx #(.PAT_W(PAT_W), .PATTERN(PAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .repeat_n(repeat_n), .gap_n(gap_n),
        .j(j), .busy(busy), .last_bit(last_bit), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic queue_transfer(input int rep, input int gap);
        for (int c = 0; c < rep; c++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                exp_q.push_back({PAT[b], 1'b1, (b == 0), 1'b0});
            if (c < rep - 1)
                for (int g = 0; g < gap; g++)
                    exp_q.push_back(4'b0100);
        end
        exp_q.push_back(4'b0001);
        $display("TXN accepted rep=%0d gap=%0d cycles=%0d at %0t", rep, gap, exp_q.size(), $time);
    endtask

    task automatic compare_outputs();
        check_val("j", j, cur[3]);
        check_val("busy", busy, cur[2]);
        check_val("last_bit", last_bit, cur[1]);
        check_val("done", done, cur[0]);
    endtask

    // one clock: model reacts to inputs sampled at the edge, DUT checked on negedge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (!cur[2] && start && (repeat_n != '0))
                queue_transfer(int'(repeat_n), int'(gap_n));
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = 4'b0;
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check_val("drain_bound", (exp_q.size() == 0), 1'b1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; repeat_n = '0; gap_n = '0;
        #12;
        compare_outputs();
        @(negedge clk);
        rst = 1'b1;

        // single copy
        start = 1'b1; repeat_n = 4'd1; gap_n = 4'd0;
        tick(); start = 1'b0;
        run_until_idle(50); tick(); tick();

        // back-to-back copies, inputs changed mid-transfer
        start = 1'b1; repeat_n = 4'd2; gap_n = 4'd0;
        tick(); start = 1'b0; repeat_n = 4'd7; gap_n = 4'd3;
        run_until_idle(50); tick();

        // gapped copies with start pulses while busy
        start = 1'b1; repeat_n = 4'd3; gap_n = 4'd2;
        tick(); start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            start = (k % 4 == 1);
            tick();
        end
        start = 1'b0;

        // start held with repeat_n = 0
        start = 1'b1; repeat_n = 4'd0; gap_n = 4'd1;
        for (int k = 0; k < 8; k++) tick();
        start = 1'b0;

        // async reset during bit 3
        start = 1'b1; repeat_n = 4'd1; gap_n = 4'd0;
        tick(); start = 1'b0;
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        exp_q.delete(); cur = 4'b0;
        compare_outputs();
        tick(); tick();
        rst = 1'b1;
        start = 1'b1; repeat_n = 4'd1;
        tick(); start = 1'b0;
        run_until_idle(50);

        // start accepted in the done cycle
        start = 1'b1; repeat_n = 4'd1;
        tick(); run_until_idle(50); start = 1'b0;
        run_until_idle(50); tick();

        // randomized transfers
        for (int t = 0; t < 30; t++) begin
            start = 1'b1;
            repeat_n = CNT_W'($urandom_range(0, 4));
            gap_n    = CNT_W'($urandom_range(0, 3));
            tick();
            for (int n = 0; n < 200 && exp_q.size() > 0; n++) begin
                start    = ($urandom_range(0, 5) == 0);
                repeat_n = CNT_W'($urandom_range(0, 15));
                gap_n    = CNT_W'($urandom_range(0, 15));
                tick();
            end
            check_val("rand_bound", (exp_q.size() == 0), 1'b1);
            start = 1'b0;
            if ($urandom_range(0, 1) == 1) tick();
        end
        start = 1'b0;
        run_until_idle(100);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
